// File: rtl/uart_rx_buffer_pkg.sv
// Shared register layout for the UART receive buffer: word-select bits, STATUS/CTRL fields.
// Pure definitions; no logic, no latency.
package uart_rx_buffer_pkg;
   localparam int WSEL_DATA_BIT    = 2;
   localparam int WSEL_STAT_BIT    = 3;
   localparam int STAT_AVAIL_BIT   = 0;
   localparam int STAT_OVF_BIT     = 1;
   localparam int STAT_FULL_BIT    = 2;
   localparam int STAT_CNT_LSB     = 4;
   localparam int CTRL_CLR_OVF_BIT = 0;
   localparam int CTRL_FLUSH_BIT   = 1;

   function automatic logic [31:0] data_word(input logic vld, input logic [7:0] dat);
      return {23'b0, vld, dat};
   endfunction
endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// Byte FIFO with flush; dout shows the head combinationally, count/full/empty are registered state.
// Push while full is refused unless a pop frees the slot in the same cycle; flush overrides push/pop.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign full      = (r_count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop & ~empty & ~flush;
   assign w_do_push = push & (~full | w_do_pop) & ~flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end
endmodule

// File: rtl/uart_rx_buffer.sv
// IO-mapped UART receive queue: DATA pops, STATUS reports, CTRL clears overflow/flushes.
// rdata registered one cycle after mem_rstrb; bytes arriving while full are dropped and flagged.
module uart_rx_buffer
   import uart_rx_buffer_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx_dv,
   input  logic [7:0]  rx_byte,
   input  logic        sel_data,
   input  logic        sel_stat,
   input  logic        mem_rstrb,
   input  logic        mem_wstrb,
   input  logic [31:0] mem_wdata,
   output logic [31:0] rdata,
   output logic        rx_avail
);
   logic [7:0]          w_head;
   logic [DEPTH_LOG2:0] w_count;
   logic                w_full;
   logic                w_empty;
   logic                w_rd_data;
   logic                w_rd_stat;
   logic                w_wr_ctrl;
   logic                w_flush;
   logic                w_clr_ovf;
   logic                w_pop;
   logic                w_ovf_set;
   logic [31:0]         w_stat;
   logic                w_unused_wdata;
   logic                r_overflow;
   logic [31:0]         r_rdata;

   assign w_rd_data = mem_rstrb & sel_data;
   assign w_rd_stat = mem_rstrb & sel_stat & ~sel_data;
   assign w_wr_ctrl = mem_wstrb & sel_stat;
   assign w_flush   = w_wr_ctrl & mem_wdata[CTRL_FLUSH_BIT];
   assign w_clr_ovf = w_wr_ctrl & mem_wdata[CTRL_CLR_OVF_BIT];
   assign w_pop     = w_rd_data & ~w_empty;
   // A same-cycle pop makes room, so only a push against a full, unpopped FIFO overflows.
   assign w_ovf_set = rx_dv & w_full & ~w_pop & ~w_flush;
   assign w_unused_wdata = ^mem_wdata[31:2];

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (rx_dv),
      .pop    (w_pop),
      .flush  (w_flush),
      .din    (rx_byte),
      .dout   (w_head),
      .count  (w_count),
      .full   (w_full),
      .empty  (w_empty)
   );

   always_comb begin
      w_stat = '0;
      w_stat[STAT_CNT_LSB +: DEPTH_LOG2+1] = w_count;
      w_stat[STAT_FULL_BIT]  = w_full;
      w_stat[STAT_OVF_BIT]   = r_overflow;
      w_stat[STAT_AVAIL_BIT] = ~w_empty;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
         r_rdata    <= '0;
      end else begin
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_clr_ovf) r_overflow <= 1'b0;
         if (w_rd_data)      r_rdata <= w_empty ? 32'h0 : data_word(1'b1, w_head);
         else if (w_rd_stat) r_rdata <= w_stat;
      end
   end

   assign rdata    = r_rdata;
   assign rx_avail = ~w_empty;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: queue-based reference model compared every cycle, plus literal reads.
module tb_uart_rx_buffer;
   import uart_rx_buffer_pkg::*;

   localparam logic [31:0] A_DATA = 32'h0040_0000 | (32'd1 << WSEL_DATA_BIT);
   localparam logic [31:0] A_STAT = 32'h0040_0000 | (32'd1 << WSEL_STAT_BIT);
   localparam logic [31:0] A_BOTH = A_DATA | A_STAT;
   localparam logic [31:0] A_NONE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = 8'h0;
   logic        sel_data = 1'b0;
   logic        sel_stat = 1'b0;
   logic        mem_rstrb = 1'b0;
   logic        mem_wstrb = 1'b0;
   logic [31:0] mem_wdata = 32'h0;
   logic [31:0] rdata;
   logic        rx_avail;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   logic [7:0]  m_q[$];
   logic        m_ovf;
   logic [31:0] m_rdata;

   uart_rx_buffer #(.DEPTH_LOG2(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rx_dv     (rx_dv),
      .rx_byte   (rx_byte),
      .sel_data  (sel_data),
      .sel_stat  (sel_stat),
      .mem_rstrb (mem_rstrb),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .rdata     (rdata),
      .rx_avail  (rx_avail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: a 16-entry queue, a sticky overflow bit, and the last read result.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_q.delete();
         m_ovf   = 1'b0;
         m_rdata = 32'h0;
      end else begin
         int  len;
         bit  rd_d, rd_s, ctrl, popped, ovf_set;
         len     = m_q.size();
         rd_d    = mem_rstrb && sel_data;
         rd_s    = mem_rstrb && sel_stat && !sel_data;
         ctrl    = mem_wstrb && sel_stat;
         popped  = 1'b0;
         ovf_set = 1'b0;
         if (rd_d)
            m_rdata = (len > 0) ? (32'h100 | 32'(m_q[0])) : 32'h0;
         else if (rd_s)
            m_rdata = (32'(len) * 16) + ((len == 16) ? 4 : 0) + (m_ovf ? 2 : 0) + ((len != 0) ? 1 : 0);
         if (ctrl && mem_wdata[1]) begin
            m_q.delete();
         end else begin
            if (rd_d && len > 0) begin
               void'(m_q.pop_front());
               popped = 1'b1;
            end
            if (rx_dv) begin
               if (len - int'(popped) < 16) m_q.push_back(rx_byte);
               else ovf_set = 1'b1;
            end
         end
         if (ctrl && mem_wdata[0]) m_ovf = 1'b0;
         if (ovf_set) m_ovf = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_rdata", rdata, m_rdata);
         chk("model_rx_avail", 32'(rx_avail), 32'(m_q.size() != 0));
      end
   end

   task automatic step(input logic dv, input logic [7:0] b, input logic rs, input logic ws,
                       input logic [31:0] addr, input logic [31:0] wd);
      rx_dv     = dv;
      rx_byte   = b;
      mem_rstrb = rs;
      mem_wstrb = ws;
      mem_wdata = wd;
      sel_data  = addr[WSEL_DATA_BIT];
      sel_stat  = addr[WSEL_STAT_BIT];
      @(posedge clk);
      #1;
      rx_dv     = 1'b0;
      mem_rstrb = 1'b0;
      mem_wstrb = 1'b0;
      sel_data  = 1'b0;
      sel_stat  = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0, A_NONE, 32'h0);
   endtask

   task automatic rd(input logic [31:0] addr, input string name, input logic [31:0] exp);
      step(1'b0, 8'h0, 1'b1, 1'b0, addr, 32'h0);
      chk(name, rdata, exp);
   endtask

   task automatic ctrl_wr(input logic [31:0] wd);
      step(1'b0, 8'h0, 1'b0, 1'b1, A_STAT, wd);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #3 resetn = 1'b1;
      @(posedge clk);
      #1;
      cmp_en = 1'b1;

      chk("reset_rdata", rdata, 32'h0);
      chk("reset_avail", 32'(rx_avail), 32'h0);
      rd(A_STAT, "t1_status", 32'h0);
      rd(A_DATA, "t1_data_empty", 32'h0);

      push(8'h41);
      push(8'h42);
      chk("t2_avail", 32'(rx_avail), 32'h1);
      rd(A_STAT, "t2_status_cnt2", 32'h21);
      rd(A_DATA, "t2_data0", 32'h141);
      rd(A_DATA, "t2_data1", 32'h142);
      rd(A_DATA, "t2_data_empty", 32'h0);
      rd(A_STAT, "t2_status_cnt0", 32'h0);
      step(1'b0, 8'h0, 1'b0, 1'b0, A_NONE, 32'h0);
      chk("t2_rdata_hold", rdata, 32'h0);

      for (int i = 0; i < 17; i++) push(8'(i));
      rd(A_STAT, "t3_status_full_ovf", 32'h107);
      for (int i = 0; i < 16; i++) rd(A_DATA, "t3_drain", 32'h100 + 32'(i));
      rd(A_STAT, "t3_status_ovf_only", 32'h2);
      ctrl_wr(32'h1);
      rd(A_STAT, "t3_status_cleared", 32'h0);

      for (int i = 0; i < 16; i++) push(8'(i));
      step(1'b1, 8'h55, 1'b1, 1'b0, A_DATA, 32'h0);
      chk("t4_pop_push_full", rdata, 32'h100);
      rd(A_STAT, "t4_status_no_ovf", 32'h105);
      for (int i = 1; i < 16; i++) rd(A_DATA, "t4_drain", 32'h100 + 32'(i));
      rd(A_DATA, "t4_last_pop", 32'h155);
      rd(A_DATA, "t4_empty", 32'h0);

      for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
      step(1'b1, 8'h77, 1'b0, 1'b1, A_STAT, 32'h2);
      rd(A_STAT, "t5_flush_status", 32'h0);
      rd(A_DATA, "t5_flush_data", 32'h0);

      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      step(1'b1, 8'hEE, 1'b0, 1'b1, A_STAT, 32'h1);
      rd(A_STAT, "clr_vs_ovf_push", 32'h107);
      ctrl_wr(32'h3);
      rd(A_STAT, "flush_and_clear", 32'h0);

      step(1'b1, 8'h99, 1'b1, 1'b0, A_DATA, 32'h0);
      chk("push_read_empty", rdata, 32'h0);
      rd(A_BOTH, "both_sel_data_wins", 32'h199);

      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
      rd(A_DATA, "t6_pre_reset", 32'h1C0);
      #2 resetn = 1'b0;
      #1;
      chk("t6_async_rdata", rdata, 32'h0);
      chk("t6_async_avail", 32'(rx_avail), 32'h0);
      @(posedge clk);
      #3 resetn = 1'b1;
      @(posedge clk);
      #1;
      rd(A_STAT, "t6_status_after", 32'h0);
      rd(A_DATA, "t6_data_after", 32'h0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
